dmem_access: RTL and testbench
==============================

# dmem_access

Data-memory access unit for the five-stage RV64 pipeline. It takes the load/store in the EX/MEM latch and runs one dbus transaction per instruction. It stalls the pipeline until the data returns and then holds the aligned, sign/zero-extended load result until the pipeline consumes it. It drives the dbus port directly and returns the load result toward the MEM/WB latch, replacing ad-hoc access tracking in the core.

## Interface
- No parameters; data width fixed at 64, bus types are `dbus_req_t` and `dbus_resp_t` from `common`.
- clk  in  1  core clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
- req_valid  in  1  EX/MEM holds a load or store.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  in  1  zero-extend load (LBU/LHU/LWU); ignored for stores and double loads.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, right-justified (unshifted).
- req_ack  in  1  pipeline advances past this instruction this cycle.
- dreq  out  dbus_req_t  valid/addr/size/strobe/data to the data bus.
- dresp  in  dbus_resp_t  only `data_ok` and `data` are used.
- stall  out  1  freeze pipeline stages F..M.
- done  out  1  result ready and held.
- rdata  out  64  extended load result; 0 for stores.
- misalign  out  1  the access that just completed was misaligned; valid while done = 1.

## Operation
- FSM states:
  - IDLE. If req_valid is high, the request is latched (write, size, unsigned, addr, wdata).
    - Misaligned request (addr not a multiple of 2^size): go to DONE with misalign = 1 and no bus access.
    - Aligned request: go to BUSY.
  - BUSY. dreq.valid = 1, and every dreq field comes from the latched request, stable for the whole state. When dresp.data_ok is high, dresp.data is captured and the state goes to DONE.
  - DONE. done = 1; rdata and misalign are held. The state goes to IDLE when req_ack is high or req_valid is low.
- dreq fields:
  - dreq.size: MSIZE1/2/4/8 from req_size.
  - dreq.addr: latched addr.
  - dreq.data: wdata << (8*addr[2:0]).
  - dreq.strobe: store only; mask 8'h01/8'h03/8'h0f/8'hff by size, shifted left by addr[2:0]. Loads use strobe 0.
- Load result: take the captured data >> (8*addr[2:0]) and truncate to the access size. Then sign-extend, or zero-extend if unsigned. A double load passes through unchanged.
- Store result: rdata = 0.
- stall = req_valid & (state != DONE). stall is low in DONE, so the pipeline may advance; req_ack is expected in that cycle.
- If req_valid drops during BUSY (flush), the transaction still completes. DONE then exits on the first cycle that has !req_valid or req_ack. A bus transaction is never abandoned except by reset.
- req_ack outside DONE is ignored.
- dreq.valid is 0 in IDLE and DONE, so exactly one bus transaction is made per instruction, even when DONE is held for many cycles.

## Timing
- Reset values: state IDLE, dreq.valid 0, dreq.strobe 0, stall follows req_valid, done 0, rdata 0, misalign 0.
- Aligned access, where data_ok comes k cycles after BUSY entry (k ≥ 0):
  - Cycle 0: IDLE with req_valid.
  - Cycles 1..1+k: BUSY.
  - Cycle 2+k: DONE.
  - Minimum latency is 2 cycles; stall is high on cycles 0..1+k.
- Misaligned access: cycle 0 IDLE, cycle 1 DONE; dreq.valid is never asserted.
- dreq.valid is still high in the data_ok cycle and drops in the next cycle.
- Back-to-back accesses: from DONE with req_ack, the state is IDLE on the next cycle and the new request is latched there. The minimum gap between two bus transactions is 2 cycles.
- Reset asserted mid-BUSY: dreq.valid drops at once, and nothing is captured.

## Test plan
- LW signed, addr 0x80001004, data_ok on the first BUSY cycle with data 0x80000001_12345678 -> BUSY lasts 1 cycle; dreq.size MSIZE4, strobe 0. DONE arrives 2 cycles after the request, with rdata 0xFFFFFFFF_80000001.
- SB, addr 0x80001005, wdata 0xAB -> strobe 0x20, dreq.data[47:40] = 0xAB, rdata 0. done is high 2 cycles after the request when data_ok is immediate.
- LH, addr 0x80001001 -> misalign = 1 and done on the next cycle. dreq.valid stays 0 throughout; rdata 0.
- LHU, addr offset 6, data_ok held off 3 cycles, data[63:48] = 0xF00D -> stall high for 5 cycles, dreq fields constant while valid, rdata 0x000000000000F00D.
- DONE held with req_ack = 0 for 3 cycles, then req_ack = 1 -> exactly one dreq.valid transaction. IDLE on the cycle after the ack.
- reset driven to 0 during BUSY -> dreq.valid, done and stall-from-state clear immediately. After reset is released, a new LD completes normally.

Source files
------------

// File: rtl/dmem_access.sv
// Data-memory access unit: one dbus transaction per load/store in EX/MEM,
// stalls the pipeline until data returns, then holds the extended result.

package common;
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dmem_access
    import common::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic        req_ack,
    output dbus_req_t   dreq,
    input  dbus_resp_t  dresp,
    output logic        stall,
    output logic        done,
    output logic [63:0] rdata,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic        l_write;
    logic [1:0]  l_size;
    logic        l_unsigned;
    logic [63:0] l_addr;
    logic [63:0] l_wdata;

    logic        req_misalign;
    logic [7:0]  size_mask;
    logic [63:0] shifted;
    logic [63:0] load_ext;

    // A request is misaligned when its address is not a multiple of the access size.
    always_comb begin
        req_misalign = 1'b0;
        case (req_size)
            2'd0: req_misalign = 1'b0;
            2'd1: req_misalign = req_addr[0];
            2'd2: req_misalign = |req_addr[1:0];
            2'd3: req_misalign = |req_addr[2:0];
            default: req_misalign = 1'b0;
        endcase
    end

    // Bus request fields come only from the latched request, so they stay
    // stable for the whole BUSY state; valid is asserted only in BUSY.
    always_comb begin
        size_mask = 8'h00;
        case (l_size)
            2'd0: size_mask = 8'h01;
            2'd1: size_mask = 8'h03;
            2'd2: size_mask = 8'h0f;
            2'd3: size_mask = 8'hff;
            default: size_mask = 8'h00;
        endcase
        dreq        = '0;
        dreq.valid  = (state == BUSY);
        dreq.addr   = l_addr;
        dreq.size   = msize_t'({1'b0, l_size});
        dreq.strobe = l_write ? (size_mask << l_addr[2:0]) : 8'h00;
        dreq.data   = l_wdata << {l_addr[2:0], 3'b000};
    end

    // Align returned data to bit 0, truncate to the access size and extend.
    always_comb begin
        shifted  = dresp.data >> {l_addr[2:0], 3'b000};
        load_ext = shifted;
        case (l_size)
            2'd0: load_ext = l_unsigned ? {56'd0, shifted[7:0]}
                                        : {{56{shifted[7]}}, shifted[7:0]};
            2'd1: load_ext = l_unsigned ? {48'd0, shifted[15:0]}
                                        : {{48{shifted[15]}}, shifted[15:0]};
            2'd2: load_ext = l_unsigned ? {32'd0, shifted[31:0]}
                                        : {{32{shifted[31]}}, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    // Pipeline is frozen whenever an access is pending and the result isn't ready.
    assign stall = req_valid & (state != DONE);

    // Access FSM: latch in IDLE, wait for data_ok in BUSY, hold result in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            l_write    <= 1'b0;
            l_size     <= 2'd0;
            l_unsigned <= 1'b0;
            l_addr     <= '0;
            l_wdata    <= '0;
            done       <= 1'b0;
            rdata      <= '0;
            misalign   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        l_write    <= req_write;
                        l_size     <= req_size;
                        l_unsigned <= req_unsigned;
                        l_addr     <= req_addr;
                        l_wdata    <= req_wdata;
                        if (req_misalign) begin
                            // No bus access for a misaligned request.
                            state    <= DONE;
                            done     <= 1'b1;
                            misalign <= 1'b1;
                            rdata    <= '0;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // A flush (req_valid low) does not abandon the transaction.
                    if (dresp.data_ok) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        misalign <= 1'b0;
                        rdata    <= l_write ? 64'd0 : load_ext;
                    end
                end
                DONE: begin
                    if (req_ack || !req_valid) begin
                        state    <= IDLE;
                        done     <= 1'b0;
                        misalign <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access.sv
// Randomized bench for dmem_access against a byte-level reference model.

module tb_dmem_access;
    import common::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        req_ack = 1'b0;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    logic        stall;
    logic        done;
    logic [63:0] rdata;
    logic        misalign;

    int n_chk = 0;
    int n_pass = 0;
    int n_txn = 0;
    logic prev_valid = 1'b0;

    logic [63:0] last_rdata;
    logic [7:0]  last_strobe;
    logic [63:0] last_ddata;
    logic        last_misalign;

    dmem_access dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ack(req_ack), .dreq(dreq), .dresp(dresp),
        .stall(stall), .done(done), .rdata(rdata), .misalign(misalign)
    );

    always #5 clk = ~clk;

    // Count bus transactions as rising edges of dreq.valid.
    always @(posedge clk) begin
        if (dreq.valid && !prev_valid) n_txn <= n_txn + 1;
        prev_valid <= dreq.valid;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference load result: pick bytes, then sign/zero extend arithmetically.
    function automatic logic [63:0] ref_load(input logic [63:0] d, input logic [63:0] a,
                                              input logic [1:0] sz, input logic uns);
        int bits;
        logic [63:0] v, m;
        bits = 8 * (1 << sz);
        v = d >> (8 * a[2:0]);
        if (bits == 64) return v;
        m = (64'd1 << bits) - 64'd1;
        v = v & m;
        if (!uns && v[bits-1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [7:0] ref_strobe(input logic w, input logic [1:0] sz,
                                              input logic [63:0] a);
        logic [15:0] m;
        if (!w) return 8'h00;
        m = ((16'd1 << (1 << sz)) - 16'd1) << a[2:0];
        return m[7:0];
    endfunction

    // One instruction from IDLE to back in IDLE. k = data_ok delay, h = extra
    // DONE hold cycles without ack, flush = drop req_valid in the first BUSY cycle.
    task automatic run_txn(input logic w, input logic [1:0] sz, input logic uns,
                           input logic [63:0] a, input logic [63:0] wd,
                           input logic [63:0] bd, input int k, input int h,
                           input bit flush);
        bit mis;
        logic [63:0] exp_rd;
        mis = (a & ((64'd1 << sz) - 64'd1)) != 64'd0;
        exp_rd = (mis || w) ? 64'd0 : ref_load(bd, a, sz, uns);

        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; req_ack = 1'b0;
        #1;
        chk("c0_stall", 64'(stall), 64'd1);
        chk("c0_valid", 64'(dreq.valid), 64'd0);
        chk("c0_done", 64'(done), 64'd0);
        tick;
        req_addr = $urandom; req_wdata = {$urandom, $urandom};

        if (!mis) begin
            for (int i = 0; i <= k; i++) begin
                if (flush && i == 0) req_valid = 1'b0;
                dresp.data_ok = (i == k);
                dresp.data = (i == k) ? bd : {$urandom, $urandom};
                #1;
                chk("busy_valid", 64'(dreq.valid), 64'd1);
                chk("busy_addr", dreq.addr, a);
                chk("busy_size", 64'(dreq.size), 64'(sz));
                chk("busy_strb", 64'(dreq.strobe), 64'(ref_strobe(w, sz, a)));
                if (w) chk("busy_data", dreq.data, wd << (8 * a[2:0]));
                chk("busy_stall", 64'(stall), flush ? 64'd0 : 64'd1);
                chk("busy_done", 64'(done), 64'd0);
                last_strobe = dreq.strobe;
                last_ddata  = dreq.data;
                tick;
            end
            dresp.data_ok = 1'b0;
            dresp.data = {$urandom, $urandom};
        end

        #1;
        chk("done", 64'(done), 64'd1);
        chk("misalign", 64'(misalign), mis ? 64'd1 : 64'd0);
        chk("rdata", rdata, exp_rd);
        chk("done_valid", 64'(dreq.valid), 64'd0);
        chk("done_stall", 64'(stall), 64'd0);
        last_rdata = rdata;
        last_misalign = misalign;

        if (flush && !mis) begin
            tick;
            chk("flush_exit", 64'(done), 64'd0);
        end else begin
            for (int j = 0; j < h; j++) begin
                tick;
                chk("hold_done", 64'(done), 64'd1);
                chk("hold_rdata", rdata, exp_rd);
                chk("hold_valid", 64'(dreq.valid), 64'd0);
            end
            req_ack = 1'b1;
            tick;
            req_ack = 1'b0;
            chk("ack_exit", 64'(done), 64'd0);
            chk("ack_valid", 64'(dreq.valid), 64'd0);
        end
    endtask

    initial begin
        int t0;
        dresp = '0;
        #2;
        chk("rst_valid", 64'(dreq.valid), 64'd0);
        chk("rst_strobe", 64'(dreq.strobe), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_mis", 64'(misalign), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        req_valid = 1'b1;
        #1;
        chk("rst_stall_rv", 64'(stall), 64'd1);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick;

        // LW signed, immediate data_ok.
        t0 = n_txn;
        run_txn(1'b0, 2'd2, 1'b0, 64'h80001004, 64'd0, 64'h80000001_12345678, 0, 0, 1'b0);
        chk("lw_rdata", last_rdata, 64'hFFFFFFFF_80000001);
        chk("lw_strobe", 64'(last_strobe), 64'd0);
        chk("lw_ntxn", 64'(n_txn - t0), 64'd1);

        // SB at byte offset 5.
        run_txn(1'b1, 2'd0, 1'b0, 64'h80001005, 64'hAB, 64'd0, 0, 0, 1'b0);
        chk("sb_strobe", 64'(last_strobe), 64'h20);
        chk("sb_byte", 64'(last_ddata[47:40]), 64'hAB);
        chk("sb_rdata", last_rdata, 64'd0);

        // Misaligned LH: no bus transaction.
        t0 = n_txn;
        run_txn(1'b0, 2'd1, 1'b0, 64'h80001001, 64'd0, 64'd0, 0, 0, 1'b0);
        chk("lh_mis", 64'(last_misalign), 64'd1);
        chk("lh_ntxn", 64'(n_txn - t0), 64'd0);

        // LHU offset 6, data_ok delayed 3 cycles, DONE held 3 cycles.
        t0 = n_txn;
        run_txn(1'b0, 2'd1, 1'b1, 64'h80001006, 64'd0, 64'hF00D_1234_5678_9ABC, 3, 3, 1'b0);
        chk("lhu_rdata", last_rdata, 64'h0000_0000_0000_F00D);
        chk("lhu_ntxn", 64'(n_txn - t0), 64'd1);

        // Reset mid-BUSY, then a normal LD.
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_addr = 64'h80002000;
        tick;
        chk("rb_valid", 64'(dreq.valid), 64'd1);
        reset = 1'b0;
        #1;
        chk("rb_valid0", 64'(dreq.valid), 64'd0);
        chk("rb_done0", 64'(done), 64'd0);
        chk("rb_stall", 64'(stall), 64'd1);
        tick;
        reset = 1'b1;
        #1;
        run_txn(1'b0, 2'd3, 1'b0, 64'h80002008, 64'd0, 64'hDEAD_BEEF_0123_4567, 1, 0, 1'b0);
        chk("ld_rdata", last_rdata, 64'hDEAD_BEEF_0123_4567);

        // Randomized mix.
        for (int n = 0; n < 120; n++) begin
            logic [63:0] a;
            logic [1:0]  sz;
            sz = 2'($urandom_range(0, 3));
            a = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
            run_txn(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom},
                    {$urandom, $urandom}, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)), ($urandom_range(0, 4) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
